// File: rtl/memory_controller.sv
// Byte-serial RAM/IO port controller: arbitrates stores, loads and fetches into byte transfers.
// Optional MEM_IO_STALL_EN: holds an IO-region store in IDLE while the UART buffer is full.
module memory_controller #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        lsb_store,
  input  logic [31:0] store_address,
  input  logic [31:0] data_store,
  input  logic [5:0]  op_type_store,
  output logic        finish_store,
  input  logic        lsb_load,
  input  logic [31:0] load_address,
  input  logic [5:0]  op_type_load,
  output logic        finish_load,
  output logic [31:0] data_load,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic        finish_fetch,
  output logic [31:0] inst_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [2:0]  state_dbg
);
  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_STORE = 3'd1, S_LOAD = 3'd2, S_FETCH = 3'd3, S_DONE = 3'd4} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_a_q, mem_a_d, addr_q, addr_d, data_q, data_d, asm_q, asm_d;
  logic [31:0] data_load_q, data_load_d, inst_out_q, inst_out_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [5:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mem_wr_q, mem_wr_d, fin_st_q, fin_st_d, fin_ld_q, fin_ld_d, fin_if_q, fin_if_d;
  logic        io_block;
  logic [2:0]  size, nxt_cnt;
  logic [31:0] byte_sh, asm_upd;

  function automatic logic [2:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      default:              op_size = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] v);
    case (op)
      OP_LB:   extend = {{24{v[7]}}, v[7:0]};
      OP_LH:   extend = {{16{v[15]}}, v[15:0]};
      OP_LBU:  extend = {24'd0, v[7:0]};
      OP_LHU:  extend = {16'd0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

`ifdef MEM_IO_STALL_EN
  assign io_block = io_buffer_full && (store_address[17:16] == IO_ADDR_HI);
`else
  logic unused_io;
  assign unused_io = io_buffer_full & (store_address[17:16] == IO_ADDR_HI);
  assign io_block  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    data_load_d = data_load_q;
    inst_out_d  = inst_out_q;
    fin_st_d    = 1'b0;
    fin_ld_d    = 1'b0;
    fin_if_d    = 1'b0;
    size        = op_size(op_q);
    nxt_cnt     = cnt_q + 3'd1;
    byte_sh     = data_q >> {nxt_cnt, 3'b000};
    // Byte k arrives while cnt_q == k+1 (one cycle after its address).
    asm_upd     = asm_q;
    if (cnt_q != 3'd0) asm_upd = asm_q | ({24'd0, mem_din} << {cnt_q - 3'd1, 3'b000});

    case (state_q)
      S_IDLE: begin
        mem_wr_d = 1'b0;
        cnt_d    = 3'd0;
        asm_d    = 32'd0;
        if (lsb_store) begin
          if (!io_block) begin
            state_d    = S_STORE;
            addr_d     = store_address;
            data_d     = data_store;
            op_d       = op_type_store;
            mem_a_d    = store_address;
            mem_dout_d = data_store[7:0];
            mem_wr_d   = 1'b1;
          end
        end else if (!roll_back && lsb_load) begin
          state_d = S_LOAD;
          addr_d  = load_address;
          op_d    = op_type_load;
          mem_a_d = load_address;
        end else if (!roll_back && ifetch_req) begin
          state_d = S_FETCH;
          addr_d  = ifetch_addr;
          op_d    = OP_LW;
          mem_a_d = ifetch_addr;
        end
      end
      S_STORE: begin
        if (cnt_q == size - 3'd1) begin
          mem_wr_d = 1'b0;
          fin_st_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d      = nxt_cnt;
          mem_a_d    = addr_q + {29'd0, nxt_cnt};
          mem_dout_d = byte_sh[7:0];
        end
      end
      S_LOAD, S_FETCH: begin
        if (roll_back) begin
          state_d = S_IDLE;
        end else begin
          asm_d = asm_upd;
          if (cnt_q == size) begin
            state_d = S_DONE;
            if (state_q == S_LOAD) begin
              data_load_d = extend(op_q, asm_upd);
              fin_ld_d    = 1'b1;
            end else begin
              inst_out_d = asm_upd;
              fin_if_d   = 1'b1;
            end
          end else begin
            cnt_d = nxt_cnt;
            if (nxt_cnt < size) mem_a_d = addr_q + {29'd0, nxt_cnt};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      op_q        <= 6'd0;
      cnt_q       <= 3'd0;
      asm_q       <= 32'd0;
      data_load_q <= 32'd0;
      inst_out_q  <= 32'd0;
      fin_st_q    <= 1'b0;
      fin_ld_q    <= 1'b0;
      fin_if_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      data_load_q <= data_load_d;
      inst_out_q  <= inst_out_d;
      fin_st_q    <= fin_st_d;
      fin_ld_q    <= fin_ld_d;
      fin_if_q    <= fin_if_d;
    end
  end

  // A flush landing on the DONE cycle of a load/fetch must still kill its pulse.
  assign finish_store = fin_st_q;
  assign finish_load  = fin_ld_q & ~roll_back;
  assign finish_fetch = fin_if_q & ~roll_back;
  assign data_load    = data_load_q;
  assign inst_out     = inst_out_q;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: a RAM model, request drivers and a scoreboard
// monitor that checks finish pulses and bus cycles against expected queues.
module tb_memory_controller;
  localparam logic [5:0] OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3, OP_LBU = 6'd4,
                         OP_LHU = 6'd5, OP_SB = 6'd6, OP_SH = 6'd7, OP_SW = 6'd8;

  logic        clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, roll_back = 1'b0;
  logic        lsb_store = 1'b0, lsb_load = 1'b0, ifetch_req = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] store_address = 32'd0, data_store = 32'd0, load_address = 32'd0, ifetch_addr = 32'd0;
  logic [5:0]  op_type_store = 6'd0, op_type_load = 6'd0;
  logic        finish_store, finish_load, finish_fetch, mem_wr;
  logic [31:0] data_load, inst_out, mem_a;
  logic [7:0]  mem_din = 8'd0, mem_dout;
  logic [2:0]  state_dbg;

  logic [7:0]  ram [0:262143];
  logic [49:0] exp_q[$];   // {kind[1:0], cycle[15:0], data[31:0]}
  logic [56:0] bus_q[$];   // {cycle[15:0], wr, addr[31:0], data[7:0]}
  int          cyc = 0, t0 = 0, errors = 0, checks = 0;
  logic        prev_fin = 1'b0;

  memory_controller dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
    .op_type_store(op_type_store), .finish_store(finish_store),
    .lsb_load(lsb_load), .load_address(load_address), .op_type_load(op_type_load),
    .finish_load(finish_load), .data_load(data_load),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .finish_fetch(finish_fetch),
    .inst_out(inst_out), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .state_dbg(state_dbg)
  );

  // Clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic req_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    op_type_store = op; store_address = a; data_store = d; lsb_store = 1'b1;
  endtask
  task automatic req_load(input logic [5:0] op, input logic [31:0] a);
    op_type_load = op; load_address = a; lsb_load = 1'b1;
  endtask
  task automatic req_fetch(input logic [31:0] a);
    ifetch_addr = a; ifetch_req = 1'b1;
  endtask
  task automatic push_resp(input logic [1:0] kind, input int rel, input logic [31:0] d);
    logic [15:0] c;
    c = 16'(t0 + rel);
    exp_q.push_back({kind, c, d});
  endtask
  task automatic push_bus(input int rel, input logic wr, input logic [31:0] a, input logic [7:0] d);
    logic [15:0] c;
    c = 16'(t0 + rel);
    bus_q.push_back({c, wr, a, d});
  endtask
  task automatic apply_ctl(input int rb_at, input int io_rel, input int stall_at);
    roll_back      = (cyc == rb_at);
    io_buffer_full = (cyc < io_rel);
    rdy_in         = !(cyc == stall_at || cyc == stall_at + 1);
  endtask

  // Holds the raised requests until each one's finish pulse, dropping it on the finish edge.
  task automatic run_reqs(input int rb_at, input int io_rel, input int stall_at);
    logic fs, fl, ff;
    int i;
    i = 0;
    apply_ctl(rb_at, io_rel, stall_at);
    while ((lsb_store || lsb_load || ifetch_req) && i < 40) begin
      @(negedge clk);
      fs = finish_store; fl = finish_load; ff = finish_fetch;
      @(posedge clk); #1;
      if (fs) lsb_store = 1'b0;
      if (fl) lsb_load = 1'b0;
      if (ff) ifetch_req = 1'b0;
      apply_ctl(rb_at, io_rel, stall_at);
      i++;
    end
    checks++;
    if (lsb_store || lsb_load || ifetch_req) begin
      errors++;
      $display("FAIL req_timeout: got pending requests after %0d cycles, required none", i);
      lsb_store = 1'b0; lsb_load = 1'b0; ifetch_req = 1'b0;
    end
    roll_back = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    int nf;
    logic [1:0]  kind;
    logic [31:0] d;
    logic [49:0] got, e;
    logic [56:0] b;
    if (rst_in) begin
      nf = int'(finish_store) + int'(finish_load) + int'(finish_fetch);
      if (nf != 0) begin
        checks++;
        kind = finish_store ? 2'd0 : (finish_load ? 2'd1 : 2'd2);
        d    = finish_store ? 32'd0 : (finish_load ? data_load : inst_out);
        got  = {kind, cyc[15:0], d};
        if (nf > 1 || prev_fin) begin
          errors++;
          $display("FAIL finish_pulse: got %0d pulses (prev=%0b), required one isolated pulse", nf, prev_fin);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_finish: got %h, required no pulse", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL response: got kind/cycle/data %h, required %h", got, e);
          end
        end
      end
      prev_fin = (nf != 0);
      while (bus_q.size() != 0 && bus_q[0][56:41] < cyc[15:0]) begin
        b = bus_q.pop_front();
        checks++; errors++;
        $display("FAIL bus_missed: got nothing at cycle %0d, required %h", b[56:41], b);
      end
      if (bus_q.size() != 0 && bus_q[0][56:41] == cyc[15:0]) begin
        b = bus_q.pop_front();
        checks++;
        if (mem_wr !== b[40] || mem_a !== b[39:8] || (b[40] && mem_dout !== b[7:0])) begin
          errors++;
          $display("FAIL bus_cycle: got wr=%b a=%h d=%h, required wr=%b a=%h d=%h",
                   mem_wr, mem_a, mem_dout, b[40], b[39:8], b[7:0]);
        end
      end else if (mem_wr) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got wr=1 a=%h d=%h, required wr=0", mem_a, mem_dout);
      end
    end else begin
      prev_fin = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'd0;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h84;
    ram[18'h180] = 8'h80;
    ram[18'h300] = 8'h13; ram[18'h301] = 8'h05; ram[18'h302] = 8'h10; ram[18'h303] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check32("rst_state", 32'(state_dbg), 32'd0);
    check32("rst_mem_a", mem_a, 32'd0);
    check32("rst_outs", {mem_dout, 5'd0, mem_wr, finish_store, finish_load}, 32'd0);
    check32("rst_data_load", data_load, 32'd0);
    rst_in = 1'b1;
    next_cycle();

    // LW 0x100: addresses in cycles 1-4, pulse cycle 6, IDLE cycle 7
    req_load(OP_LW, 32'h100); t0 = cyc;
    push_bus(1, 1'b0, 32'h100, 8'h0); push_bus(2, 1'b0, 32'h101, 8'h0);
    push_bus(3, 1'b0, 32'h102, 8'h0); push_bus(4, 1'b0, 32'h103, 8'h0);
    push_resp(2'd1, 6, 32'h84332211);
    run_reqs(-10, 0, -10);
    check32("lw_idle_c7", 32'(state_dbg), 32'd0);

    // Byte/half extension
    req_load(OP_LB, 32'h180); t0 = cyc; push_resp(2'd1, 3, 32'hFFFFFF80); run_reqs(-10, 0, -10);
    req_load(OP_LBU, 32'h180); t0 = cyc; push_resp(2'd1, 3, 32'h00000080); run_reqs(-10, 0, -10);
    req_load(OP_LH, 32'h102); t0 = cyc; push_resp(2'd1, 4, 32'hFFFF8433); run_reqs(-10, 0, -10);
    req_load(OP_LHU, 32'h102); t0 = cyc; push_resp(2'd1, 4, 32'h00008433); run_reqs(-10, 0, -10);

    // SH then read back
    req_store(OP_SH, 32'h200, 32'hABCD1234); t0 = cyc;
    push_bus(1, 1'b1, 32'h200, 8'h34); push_bus(2, 1'b1, 32'h201, 8'h12);
    push_resp(2'd0, 3, 32'd0);
    run_reqs(-10, 0, -10);
    req_load(OP_LHU, 32'h200); t0 = cyc; push_resp(2'd1, 4, 32'h00001234); run_reqs(-10, 0, -10);

    // All three requests at once: store, then load, then fetch
    req_store(OP_SB, 32'h210, 32'h0000005A); req_load(OP_LW, 32'h100); req_fetch(32'h300); t0 = cyc;
    push_bus(1, 1'b1, 32'h210, 8'h5A);
    push_resp(2'd0, 2, 32'd0); push_resp(2'd1, 9, 32'h84332211); push_resp(2'd2, 16, 32'h00100513);
    run_reqs(-10, 0, -10);

    // roll_back in cycle 3 of an LW: abort, mem_a holds, IDLE in cycle 4
    req_load(OP_LW, 32'h100); t0 = cyc;
    push_bus(3, 1'b0, 32'h102, 8'h0); push_bus(4, 1'b0, 32'h102, 8'h0);
    repeat (3) next_cycle();
    roll_back = 1'b1;
    next_cycle();
    roll_back = 1'b0; lsb_load = 1'b0;
    check32("rb_lw_idle", 32'(state_dbg), 32'd0);
    repeat (4) next_cycle();

    // roll_back on the DONE cycle of an LB suppresses the pulse
    req_load(OP_LB, 32'h180); t0 = cyc;
    repeat (3) next_cycle();
    roll_back = 1'b1;
    next_cycle();
    roll_back = 1'b0; lsb_load = 1'b0;
    check32("rb_done_idle", 32'(state_dbg), 32'd0);
    repeat (3) next_cycle();

    // roll_back during SW has no effect
    req_store(OP_SW, 32'h220, 32'hDEADBEEF); t0 = cyc;
    push_bus(1, 1'b1, 32'h220, 8'hEF); push_bus(2, 1'b1, 32'h221, 8'hBE);
    push_bus(3, 1'b1, 32'h222, 8'hAD); push_bus(4, 1'b1, 32'h223, 8'hDE);
    push_resp(2'd0, 5, 32'd0);
    run_reqs(t0 + 3, 0, -10);
    req_load(OP_LW, 32'h220); t0 = cyc; push_resp(2'd1, 6, 32'hDEADBEEF); run_reqs(-10, 0, -10);

    // rdy_in low for two LOAD cycles delays the LB pulse by two
    req_load(OP_LB, 32'h180); t0 = cyc; push_resp(2'd1, 5, 32'hFFFFFF80); run_reqs(-10, 0, t0 + 2);

    // IO-region store with the UART buffer full for 5 cycles
    req_store(OP_SB, 32'h30000, 32'h00000077); t0 = cyc;
`ifdef MEM_IO_STALL_EN
    push_bus(6, 1'b1, 32'h30000, 8'h77); push_resp(2'd0, 7, 32'd0);
    run_reqs(-10, t0 + 5, -10);
`else
    push_bus(1, 1'b1, 32'h30000, 8'h77); push_resp(2'd0, 2, 32'd0);
    run_reqs(-10, t0 + 5, -10);
`endif

    // Asynchronous reset mid-LW clears every output at once
    req_load(OP_LW, 32'h100); t0 = cyc;
    repeat (3) next_cycle();
    #2 rst_in = 1'b0;
    #1;
    check32("arst_state", 32'(state_dbg), 32'd0);
    check32("arst_mem_a", mem_a, 32'd0);
    check32("arst_data_load", data_load, 32'd0);
    check32("arst_inst_out", inst_out, 32'd0);
    check32("arst_flags", {mem_dout, 5'd0, mem_wr, finish_store, finish_load, finish_fetch}, 32'd0);
    lsb_load = 1'b0;
    next_cycle();
    rst_in = 1'b1;
    repeat (3) next_cycle();

    check32("exp_q_empty", exp_q.size(), 32'd0);
    check32("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sole owner of the byte-wide RAM/IO port. Sits directly downstream of load_store_buffer and the instruction fetcher.
- Arbitrates committed stores, speculative loads and instruction fetches. Serialises each access into byte transfers, then returns finish_store, finish_load with data_load, or finish_fetch with inst_out.
- Loads are sign- or zero-extended here, so load_store_buffer broadcasts data_load unchanged.

Parameters:
- IO_ADDR_HI, 2'b11, value of address bits [17:16] that marks the memory-mapped IO region.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- rdy_in  input  1  pause when low; all state and outputs hold
- roll_back  input  1  misprediction flush
- lsb_store  input  1  store request, held high until finish_store
- store_address  input  32  store byte address
- data_store  input  32  store data, low bytes used
- op_type_store  input  6  SB/SH/SW op code (operaType.v)
- finish_store  output  1  one-cycle store-done pulse
- lsb_load  input  1  load request, held high until finish_load
- load_address  input  32  load byte address
- op_type_load  input  6  LB/LH/LW/LBU/LHU op code
- finish_load  output  1  one-cycle load-done pulse
- data_load  output  32  extended load result, valid with finish_load
- ifetch_req  input  1  fetch request, held high until finish_fetch
- ifetch_addr  input  32  instruction address
- finish_fetch  output  1  one-cycle fetch-done pulse
- inst_out  output  32  fetched word, valid with finish_fetch
- mem_din  input  8  RAM read byte, valid the cycle after its address
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  write enable (1 = write)
- io_buffer_full  input  1  UART output buffer full

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - finish_store=finish_load=finish_fetch=0.
  - data_load=0, inst_out=0, byte counter=0, assembly register=0.
  - Reset mid-transfer abandons the transfer silently.
- States: IDLE, STORE, LOAD, FETCH, DONE.
- Arbitration in IDLE only, priority lsb_store > lsb_load > ifetch_req.
  - A store is already committed, so it always wins.
  - Requests are sampled in IDLE. Address, op and data are latched internally at the accepting edge.
- Size: byte=1, half=2, word=4; n denotes this size. Bytes are little-endian at addr, addr+1, ...; 32-bit address wrap is ignored.
- Load/fetch timing (request seen in IDLE in cycle 0):
  - mem_a=addr+k is driven in cycle k+1, with mem_wr=0.
  - Byte k is captured from mem_din at the end of cycle k+2.
  - The finish pulse and data are high in cycle n+2; this is DONE.
  - LW → cycle 6. LB → cycle 3. Fetch → cycle 6.
- Store timing:
  - mem_a=addr+k, mem_dout=data_store[8k+7:8k] and mem_wr=1 in cycle k+1.
  - finish_store is high in cycle n+1 (DONE), with mem_wr=0.
- Extension: LB/LH sign-extend bit 7/15. LBU/LHU zero-extend.
- DONE lasts exactly 1 cycle and accepts no request, because the requester drops its request on the finish edge. Next cycle is IDLE.
- finish_* are 1-cycle pulses, never two back-to-back. mem_wr is 0 in every state except STORE.
- roll_back, in any cycle:
  - LOAD/FETCH abort to IDLE next edge, with no finish pulse. mem_a holds, mem_wr=0.
  - A roll_back coincident with DONE of a load/fetch suppresses that pulse.
  - STORE and store DONE are unaffected.
  - In IDLE, a roll_back cycle accepts no load/fetch; a store may still be accepted.
- rdy_in low freezes everything, including the mem_din capture. The RAM stalls identically.

Optional Feature:
- MEM_IO_STALL_EN.
- Defined: a store with store_address[17:16]==IO_ADDR_HI is not started while io_buffer_full=1. The stall happens in IDLE; loads and fetches are blocked behind it. A store already in progress is not interrupted.
- Not defined: io_buffer_full is ignored.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x84 → mem_a 0x100..0x103 in cycles 1-4; finish_load cycle 6 with data_load=0x84332211; IDLE cycle 7.
- LB and LBU at a byte of 0x80 → data_load 0xFFFFFF80 and 0x00000080 respectively; each pulse in cycle 3.
- SH 0xABCD1234 to 0x200 → mem_wr=1 with (0x200,0x34), (0x201,0x12) in cycles 1-2; finish_store cycle 3; 0x200/0x201 read back as 0x1234.
- lsb_store, lsb_load, ifetch_req all high in cycle 0 → store served first, then the load, then the fetch. Each is separated by one DONE cycle; no back-to-back pulses.
- roll_back in cycle 3 of an LW → no finish_load; IDLE in cycle 4. Same roll_back during an SW → finish_store still in cycle 5 with all 4 bytes written.
- MEM_IO_STALL_EN defined, SB to 0x30000 with io_buffer_full=1 for 5 cycles → mem_wr stays 0 until release, then the write occurs. Assert rst_in low mid-LW → all outputs 0 immediately.
